// File: rtl/shield_pwr_sequencer_pkg.sv
// Shared definitions for the shield power sequencer: port FSM states, register
// map offsets, CTRL/STATUS bit positions, reset values and a byte-lane merge helper.
package shield_pwr_sequencer_pkg;

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_RAMP    = 3'd1;
  localparam logic [2:0] ST_ON      = 3'd2;
  localparam logic [2:0] ST_FAULT   = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RAMP   = 2'd2;
  localparam logic [1:0] ADDR_COOL   = 2'd3;

  localparam int CTRL_A_EN     = 0;
  localparam int CTRL_B_EN     = 1;
  localparam int CTRL_A_HOE    = 8;
  localparam int CTRL_B_HOE    = 9;
  localparam int CTRL_A_LOE    = 16;
  localparam int CTRL_B_LOE    = 17;
  localparam int CTRL_A_IRQ_EN = 24;
  localparam int CTRL_B_IRQ_EN = 25;

  localparam int STAT_A_STATE_LSB = 0;
  localparam int STAT_B_STATE_LSB = 8;
  localparam int STAT_A_FAULT     = 16;
  localparam int STAT_B_FAULT     = 17;
  localparam int STAT_A_RETRY_LSB = 20;
  localparam int STAT_B_RETRY_LSB = 24;
  localparam int STAT_B_OCN       = 30;
  localparam int STAT_A_OCN       = 31;

  // Only the implemented CTRL bits are stored; the rest read back as 0.
  localparam logic [31:0] CTRL_MASK = 32'h0303_0303;
  localparam logic [31:0] RAMP_RST  = 32'd1000;
  localparam logic [31:0] COOL_RST  = 32'd50000;

  typedef struct packed {
    logic en;
    logic hoe_req;
    logic loe_req;
    logic irq_en;
  } port_ctrl_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/shield_port_fsm.sv
// One shield port: power FSM with over-current debounce, retry count and a
// shared ramp/cooldown down-counter. Outputs are registered from the next state.
module shield_port_fsm
  import shield_pwr_sequencer_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             hoe_req,
  input  logic             loe_req,
  input  logic             ocn,
  input  logic [CNT_W-1:0] ramp_cycles,
  input  logic [CNT_W-1:0] cooldown_cycles,
  output logic [2:0]       state,
  output logic [1:0]       retry,
  output logic             fault_set,
  output logic             pwren,
  output logic             hoe,
  output logic             loe
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);

  logic [2:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, ramp_load, cool_load;
  logic [DEB_W-1:0] deb_q;
  logic [1:0]       retry_q, retry_nxt;
  logic             in_run, oc_qual, cnt_done;

  // Counter holds "cycles left minus one", so a programmed 0 behaves like 1.
  assign ramp_load = (ramp_cycles == '0) ? '0 : ramp_cycles - CNT_W'(1);
  assign cool_load = (cooldown_cycles == '0) ? '0 : cooldown_cycles - CNT_W'(1);
  assign cnt_done  = (cnt_q == '0);
  assign in_run    = (state_q == ST_RAMP) || (state_q == ST_ON);
  assign oc_qual   = in_run && !ocn && (deb_q >= DEB_W'(DEBOUNCE - 1));

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    retry_nxt = retry_q;
    case (state_q)
      ST_OFF: begin
        if (en) begin
          state_nxt = ST_RAMP;
          cnt_nxt   = ramp_load;
        end
      end
      ST_RAMP, ST_ON: begin
        if (!en) begin
          state_nxt = ST_OFF;
        end else if (oc_qual) begin
          state_nxt = ST_FAULT;
          cnt_nxt   = cool_load;
        end else if (state_q == ST_RAMP) begin
          if (cnt_done) state_nxt = ST_ON;
          else          cnt_nxt   = cnt_q - CNT_W'(1);
        end
      end
      ST_FAULT: begin
        if (!en) begin
          state_nxt = ST_OFF;
        end else if (cnt_done) begin
          if (retry_q < 2'(MAX_RETRY)) begin
            state_nxt = ST_RAMP;
            retry_nxt = retry_q + 2'd1;
            cnt_nxt   = ramp_load;
          end else begin
            state_nxt = ST_LOCKOUT;
          end
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (!en) state_nxt = ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase
    if (state_nxt == ST_OFF) retry_nxt = '0;
  end

  assign fault_set = (state_nxt == ST_FAULT) && (state_q != ST_FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      retry_q <= '0;
      deb_q   <= '0;
      pwren   <= 1'b1;
      hoe     <= 1'b0;
      loe     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      retry_q <= retry_nxt;
      if (in_run && !ocn) begin
        if (deb_q != DEB_W'(DEBOUNCE)) deb_q <= deb_q + DEB_W'(1);
      end else begin
        deb_q <= '0;
      end
      pwren <= !((state_nxt == ST_RAMP) || (state_nxt == ST_ON));
      hoe   <= (state_nxt == ST_ON) && hoe_req;
      loe   <= (state_nxt == ST_ON) && loe_req;
    end
  end

  assign state = state_q;
  assign retry = retry_q;

endmodule

// File: rtl/shield_pwr_sequencer.sv
// Two-port shield power sequencer: Avalon-MM register file, sticky fault bits,
// level interrupt, and one shield_port_fsm per port.
module shield_pwr_sequencer
  import shield_pwr_sequencer_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [1:0]  avs_ctrl_address,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  output logic        ins_OC_irq,
  input  logic        coe_A_OCN,
  input  logic        coe_B_OCN,
  output logic        coe_A_PWREN,
  output logic        coe_B_PWREN,
  output logic        coe_A_HOE,
  output logic        coe_A_LOE,
  output logic        coe_B_HOE,
  output logic        coe_B_LOE
);

  logic [31:0]      ctrl_q;
  logic             a_fault_q, b_fault_q, irq_q;
  logic [CNT_W-1:0] ramp_q, cool_q;
  port_ctrl_t       a_cfg, b_cfg;
  logic [2:0]       a_state, b_state;
  logic [1:0]       a_retry, b_retry;
  logic             a_fault_set, b_fault_set;
  logic [31:0]      ramp_wr, cool_wr, status;
  logic             wr_ctrl, wr_status, wr_ramp, wr_cool, a_w1c, b_w1c;
  logic             unused_ok;

  // Bus handshake: zero wait states; a write is taken on any edge with
  // avs_ctrl_write=1, reads are pure combinational decode of the address.
  assign avs_ctrl_waitrequest = 1'b0;

  assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL);
  assign wr_status = avs_ctrl_write && (avs_ctrl_address == ADDR_STATUS);
  assign wr_ramp   = avs_ctrl_write && (avs_ctrl_address == ADDR_RAMP);
  assign wr_cool   = avs_ctrl_write && (avs_ctrl_address == ADDR_COOL);
  assign a_w1c     = wr_status && avs_ctrl_byteenable[STAT_A_FAULT/8] && avs_ctrl_writedata[STAT_A_FAULT];
  assign b_w1c     = wr_status && avs_ctrl_byteenable[STAT_B_FAULT/8] && avs_ctrl_writedata[STAT_B_FAULT];
  assign ramp_wr   = be_merge(32'(ramp_q), avs_ctrl_writedata, avs_ctrl_byteenable);
  assign cool_wr   = be_merge(32'(cool_q), avs_ctrl_writedata, avs_ctrl_byteenable);

  assign a_cfg = '{en: ctrl_q[CTRL_A_EN], hoe_req: ctrl_q[CTRL_A_HOE],
                   loe_req: ctrl_q[CTRL_A_LOE], irq_en: ctrl_q[CTRL_A_IRQ_EN]};
  assign b_cfg = '{en: ctrl_q[CTRL_B_EN], hoe_req: ctrl_q[CTRL_B_HOE],
                   loe_req: ctrl_q[CTRL_B_LOE], irq_en: ctrl_q[CTRL_B_IRQ_EN]};

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      ctrl_q    <= '0;
      a_fault_q <= 1'b0;
      b_fault_q <= 1'b0;
      ramp_q    <= RAMP_RST[CNT_W-1:0];
      cool_q    <= COOL_RST[CNT_W-1:0];
      irq_q     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= be_merge(ctrl_q, avs_ctrl_writedata, avs_ctrl_byteenable) & CTRL_MASK;
      if (wr_ramp) ramp_q <= ramp_wr[CNT_W-1:0];
      if (wr_cool) cool_q <= cool_wr[CNT_W-1:0];
      // A new fault entry beats a simultaneous write-1-to-clear.
      if (a_fault_set)  a_fault_q <= 1'b1;
      else if (a_w1c)   a_fault_q <= 1'b0;
      if (b_fault_set)  b_fault_q <= 1'b1;
      else if (b_w1c)   b_fault_q <= 1'b0;
      irq_q <= (a_fault_q && a_cfg.irq_en) || (b_fault_q && b_cfg.irq_en);
    end
  end

  assign ins_OC_irq = irq_q;

  always_comb begin
    status = '0;
    status[STAT_A_STATE_LSB +: 3] = a_state;
    status[STAT_B_STATE_LSB +: 3] = b_state;
    status[STAT_A_FAULT]          = a_fault_q;
    status[STAT_B_FAULT]          = b_fault_q;
    status[STAT_A_RETRY_LSB +: 2] = a_retry;
    status[STAT_B_RETRY_LSB +: 2] = b_retry;
    status[STAT_B_OCN]            = !coe_B_OCN;
    status[STAT_A_OCN]            = !coe_A_OCN;
  end

  always_comb begin
    avs_ctrl_readdata = '0;
    case (avs_ctrl_address)
      ADDR_CTRL:   avs_ctrl_readdata = ctrl_q;
      ADDR_STATUS: avs_ctrl_readdata = status;
      ADDR_RAMP:   avs_ctrl_readdata = 32'(ramp_q);
      ADDR_COOL:   avs_ctrl_readdata = 32'(cool_q);
      default:     avs_ctrl_readdata = '0;
    endcase
  end

  assign unused_ok = &{1'b0, avs_ctrl_read, ramp_wr, cool_wr};

  shield_port_fsm #(.DEBOUNCE(DEBOUNCE), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) u_port_a (
    .clk            (csi_MCLK_clk),
    .reset          (rsi_MRST_reset),
    .en             (a_cfg.en),
    .hoe_req        (a_cfg.hoe_req),
    .loe_req        (a_cfg.loe_req),
    .ocn            (coe_A_OCN),
    .ramp_cycles    (ramp_q),
    .cooldown_cycles(cool_q),
    .state          (a_state),
    .retry          (a_retry),
    .fault_set      (a_fault_set),
    .pwren          (coe_A_PWREN),
    .hoe            (coe_A_HOE),
    .loe            (coe_A_LOE)
  );

  shield_port_fsm #(.DEBOUNCE(DEBOUNCE), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) u_port_b (
    .clk            (csi_MCLK_clk),
    .reset          (rsi_MRST_reset),
    .en             (b_cfg.en),
    .hoe_req        (b_cfg.hoe_req),
    .loe_req        (b_cfg.loe_req),
    .ocn            (coe_B_OCN),
    .ramp_cycles    (ramp_q),
    .cooldown_cycles(cool_q),
    .state          (b_state),
    .retry          (b_retry),
    .fault_set      (b_fault_set),
    .pwren          (coe_B_PWREN),
    .hoe            (coe_B_HOE),
    .loe            (coe_B_LOE)
  );

endmodule
